// File: rtl/key_hex_counter_pkg.sv
// Shared constants for the key-driven hex counter:
// debounce FSM state encodings and default timing values.
package key_hex_counter_pkg;

  typedef enum logic [1:0] {
    IDLE_HI = 2'd0,
    CNT_LO  = 2'd1,
    IDLE_LO = 2'd2,
    CNT_HI  = 2'd3
  } db_state_t;

  localparam int CLK_FREQ_DEF    = 12000000;
  localparam int DEBOUNCE_MS_DEF = 20;

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer plus debounce FSM.
// Emits a single-cycle pulse on each debounced press.
module key_debounce
  import key_hex_counter_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      state <= IDLE_HI;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      meta  <= key_n;
      sync  <= meta;
      pulse <= 1'b0;
      unique case (state)
        IDLE_HI: begin
          if (!sync) begin
            state <= CNT_LO;
            cnt   <= '0;
          end
        end
        CNT_LO: begin
          if (sync) begin
            state <= IDLE_HI;
          end else if (cnt == LAST) begin
            state <= IDLE_LO;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE_LO: begin
          if (sync) begin
            state <= CNT_HI;
            cnt   <= '0;
          end
        end
        CNT_HI: begin
          // release settles silently
          if (!sync) begin
            state <= IDLE_LO;
          end else if (cnt == LAST) begin
            state <= IDLE_HI;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE_HI;
      endcase
    end
  end

endmodule

// File: rtl/key_hex_counter.sv
// Two debounced keys stepping a 4-bit wrap-around value.
// Reset asserts asynchronously and releases in step with clk.
module key_hex_counter
  import key_hex_counter_pkg::*;
#(
  parameter int CLK_FREQ    = CLK_FREQ_DEF,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  output logic [3:0] sw,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  logic rst_q1;
  logic rst_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q1 <= 1'b1;
      rst_q2 <= 1'b1;
    end else begin
      rst_q1 <= 1'b0;
      rst_q2 <= rst_q1;
    end
  end

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (
    .clk   (clk),
    .rst   (rst_q2),
    .key_n (key_inc_n),
    .pulse (inc_pulse)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dec (
    .clk   (clk),
    .rst   (rst_q2),
    .key_n (key_dec_n),
    .pulse (dec_pulse)
  );

  // simultaneous presses cancel
  always_ff @(posedge clk or posedge rst_q2) begin
    if (rst_q2) begin
      sw <= 4'h0;
    end else if (inc_pulse && !dec_pulse) begin
      sw <= sw + 4'h1;
    end else if (dec_pulse && !inc_pulse) begin
      sw <= sw - 4'h1;
    end
  end

endmodule

// File: tb/tb_key_hex_counter.sv
// Directed self-checking bench for key_hex_counter.
// DB_CYCLES = 4, so a clean press pulses 7 cycles after the edge.
module tb_key_hex_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [3:0] sw;
  logic       inc_pulse;
  logic       dec_pulse;

  int errors = 0;
  int checks = 0;
  int inc_cnt = 0;
  int dec_cnt = 0;
  int both_cnt = 0;

  key_hex_counter #(.DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_inc_n (key_inc_n),
    .key_dec_n (key_dec_n),
    .sw        (sw),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_pulse) inc_cnt++;
    if (dec_pulse) dec_cnt++;
    if (inc_pulse && dec_pulse) both_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic inc, input logic dec);
    key_inc_n = ~inc;
    key_dec_n = ~dec;
    tick(10);
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    tick(10);
  endtask

  initial begin
    logic [20:1] pv;
    logic [3:0]  s7;
    logic [3:0]  s8;
    int          first;
    int          base;
    int          dbase;

    tick(3);
    chk("rst_sw", 32'(sw), 32'h0);
    chk("rst_inc", 32'(inc_pulse), 32'h0);
    chk("rst_dec", 32'(dec_pulse), 32'h0);
    rst = 1'b0;
    tick(4);

    // clean press held 20 cycles
    pv = '0;
    s7 = 4'hx;
    s8 = 4'hx;
    key_inc_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      pv[i] = inc_pulse;
      if (i == 7) s7 = sw;
      if (i == 8) s8 = sw;
    end
    chk("latency_pattern", 32'(pv), 32'h40);
    chk("sw_at_pulse", 32'(s7), 32'h0);
    chk("sw_after_pulse", 32'(s8), 32'h1);
    key_inc_n = 1'b1;
    tick(10);
    chk("one_pulse_held", 32'(inc_cnt), 32'd1);

    for (int k = 2; k <= 16; k++) begin
      press(1'b1, 1'b0);
      chk($sformatf("inc_%0d", k), 32'(sw), 32'(k % 16));
    end

    press(1'b0, 1'b1);
    chk("dec_wrap", 32'(sw), 32'hf);

    // bounce: low 2, high 1, three times, then steady low
    base = inc_cnt;
    for (int r = 0; r < 3; r++) begin
      key_inc_n = 1'b0;
      tick(2);
      key_inc_n = 1'b1;
      tick(1);
    end
    chk("bounce_no_early", 32'(inc_cnt - base), 32'd0);
    key_inc_n = 1'b0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (inc_pulse && first == 0) first = i;
    end
    key_inc_n = 1'b1;
    tick(10);
    chk("bounce_latency", 32'(first), 32'd7);
    chk("bounce_count", 32'(inc_cnt - base), 32'd1);
    chk("bounce_sw", 32'(sw), 32'h0);

    base = inc_cnt;
    key_inc_n = 1'b0;
    tick(3);
    key_inc_n = 1'b1;
    tick(15);
    chk("glitch_count", 32'(inc_cnt - base), 32'd0);
    chk("glitch_sw", 32'(sw), 32'h0);

    base = both_cnt;
    dbase = dec_cnt;
    press(1'b1, 1'b1);
    chk("both_same_cycle", 32'(both_cnt - base), 32'd1);
    chk("both_dec_count", 32'(dec_cnt - dbase), 32'd1);
    chk("both_sw", 32'(sw), 32'h0);

    press(1'b1, 1'b0);
    chk("pre_rst_sw", 32'(sw), 32'h1);

    // reset while the inc FSM is counting
    base = inc_cnt;
    key_inc_n = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    chk("rst_mid_sw", 32'(sw), 32'h0);
    chk("rst_mid_inc", 32'(inc_pulse), 32'h0);
    tick(3);
    chk("rst_no_pulse", 32'(inc_cnt - base), 32'd0);
    rst = 1'b0;
    tick(20);
    chk("held_fresh_pulse", 32'(inc_cnt - base), 32'd1);
    chk("held_fresh_sw", 32'(sw), 32'h1);
    key_inc_n = 1'b1;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
